// File: rtl/if_fetch_pkg.sv
// Shared types and sizing for the instruction-fetch stage and its direct-mapped icache.
package if_fetch_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned INST_W       = 32;
  localparam int unsigned ICACHE_LINES = 64;
  localparam int unsigned ICACHE_IDX_W = 6;
  localparam int unsigned TAG_W        = ADDR_W - ICACHE_IDX_W - 2;

  localparam logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h0000_0000);
  localparam logic [INST_W-1:0] ZERO_WORD = INST_W'(32'h0000_0000);

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  // Payload presented across the IF/ID boundary.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              valid;
  } fetch_out_t;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: ID/EX control, memory-controller handshake and IF/ID payload.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic              stall_i;
  logic              jump_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ready_i;
  logic [INST_W-1:0] mem_inst_i;
  logic [ADDR_W-1:0] pc_o;
  logic [INST_W-1:0] inst_o;
  logic              valid_o;

  modport master (
    output stall_i, jump_i, jump_addr_i, mem_ready_i, mem_inst_i,
    input  mem_req_o, mem_addr_o, pc_o, inst_o, valid_o
  );

  modport slave (
    input  stall_i, jump_i, jump_addr_i, mem_ready_i, mem_inst_i,
    output mem_req_o, mem_addr_o, pc_o, inst_o, valid_o
  );

endinterface

// File: rtl/if_fetch_icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, single write port.
module icache_dm
  import if_fetch_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ICACHE_IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0]        rd_tag,
  output logic                    hit_c,
  output logic [INST_W-1:0]       rd_word_c,
  input  logic                    we,
  input  logic [ICACHE_IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]        wr_tag,
  input  logic [INST_W-1:0]       wr_word
);

  logic [ICACHE_LINES-1:0] valid_q;
  logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
  logic [INST_W-1:0]       data_mem [ICACHE_LINES];

  // Only the valid bits are reset; tag/data content is don't-care until filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_word;
    end
  end

  always_comb begin
    hit_c     = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    rd_word_c = data_mem[rd_idx];
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, miss-handling FSM and IF/ID output registers around icache_dm.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  if_fetch_if.slave  bus
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  fetch_out_t        out_q, out_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              hit_c;
  logic [INST_W-1:0] hit_word_c;
  logic              fill_c;

  // A fill is only legal while a request is outstanding; rdy low suppresses it.
  assign fill_c = rdy && (state_q != IF_IDLE) && bus.mem_ready_i;

  icache_dm u_icache (
    .clk       (clk),
    .rst_n     (rst),
    .rd_idx    (pc_q[ICACHE_IDX_W+1:2]),
    .rd_tag    (pc_q[ADDR_W-1:ICACHE_IDX_W+2]),
    .hit_c     (hit_c),
    .rd_word_c (hit_word_c),
    .we        (fill_c),
    .wr_idx    (mem_addr_q[ICACHE_IDX_W+1:2]),
    .wr_tag    (mem_addr_q[ADDR_W-1:ICACHE_IDX_W+2]),
    .wr_word   (bus.mem_inst_i)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IF_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_IDLE: if (!bus.jump_i && !bus.stall_i && !hit_c) state_d = IF_WAIT;
      IF_WAIT: begin
        if (bus.mem_ready_i)  state_d = IF_IDLE;
        else if (bus.jump_i)  state_d = IF_DROP;
      end
      IF_DROP: if (bus.mem_ready_i) state_d = IF_IDLE;
      default: state_d = IF_IDLE;
    endcase
  end

  // Next values of the PC, IF/ID payload and memory request.
  always_comb begin
    pc_d       = pc_q;
    out_d      = out_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    unique case (state_q)
      IF_IDLE: begin
        if (bus.jump_i) begin
          pc_d        = bus.jump_addr_i;
          out_d.valid = 1'b0;
        end else if (bus.stall_i) begin
          pc_d = pc_q;
        end else if (hit_c) begin
          out_d = '{pc: pc_q, inst: hit_word_c, valid: 1'b1};
          pc_d  = pc_q + ADDR_W'(4);
        end else begin
          mem_req_d   = 1'b1;
          mem_addr_d  = pc_q;
          out_d.valid = 1'b0;
        end
      end
      IF_WAIT: begin
        if (bus.mem_ready_i) mem_req_d = 1'b0;
        if (bus.jump_i) begin
          pc_d        = bus.jump_addr_i;
          out_d.valid = 1'b0;
        end else if (bus.mem_ready_i && !bus.stall_i) begin
          out_d = '{pc: pc_q, inst: bus.mem_inst_i, valid: 1'b1};
          pc_d  = pc_q + ADDR_W'(4);
        end
      end
      IF_DROP: begin
        if (bus.mem_ready_i) mem_req_d = 1'b0;
        if (bus.jump_i)      pc_d      = bus.jump_addr_i;
      end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      out_q      <= '{pc: ADDR_W'(0), inst: ZERO_WORD, valid: 1'b0};
      mem_req_q  <= 1'b0;
      mem_addr_q <= ADDR_W'(0);
    end else if (rdy) begin
      pc_q       <= pc_d;
      out_q      <= out_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign bus.pc_o       = out_q.pc;
  assign bus.inst_o     = out_q.inst;
  assign bus.valid_o    = out_q.valid;
  assign bus.mem_req_o  = mem_req_q;
  assign bus.mem_addr_o = mem_addr_q;

endmodule
